cpu_sequencer: RTL



---
 rtl/cpu_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 4-bit CPU: owns PC, IR, immediate and Z/C flags.
// Optional `SINGLE_STEP_EN adds a step input and a PAUSE state after every EXEC.
module cpu_sequencer #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [7:0]      instr_i,
  input  logic            alu_zero,
  input  logic            alu_carry,
  output logic [PC_W-1:0] pc_o,
  output logic [1:0]      rf_r_addr_a,
  output logic [1:0]      rf_r_addr_b,
  output logic [1:0]      rf_w_addr,
  output logic            rf_we,
  output logic [2:0]      alu_op,
  output logic [1:0]      wb_sel,
  output logic [3:0]      imm_o,
  output logic            busy,
  output logic            halted,
  output logic            flag_z,
  output logic            flag_c
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FETCH2 = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
`ifdef SINGLE_STEP_EN
    , S_PAUSE = 3'd5
`endif
  } state_t;

  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [3:0]      imm_q, imm_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_c_q, flag_c_d;
  logic            rf_we_q, rf_we_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic [3:0]      dec_op;
  logic            enter_exec;
  logic [3:0]      exec_op;

  assign exec_op = ir_q[7:4];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    imm_d      = imm_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    rf_we_d    = 1'b0;
    alu_op_d   = alu_op_q;
    wb_sel_d   = wb_sel_q;
    dec_op     = ir_q[7:4];
    enter_exec = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d     = '0;
          flag_z_d = 1'b0;
          flag_c_d = 1'b0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d   = instr_i;
        pc_d   = pc_q + PC_W'(1);
        dec_op = instr_i[7:4];
        if (instr_i[7:4] >= OP_LDI && instr_i[7:4] <= OP_JC) begin
          state_d = S_FETCH2;
        end else if (instr_i[7:4] == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d    = S_EXEC;
          enter_exec = 1'b1;
        end
      end
      S_FETCH2: begin
        imm_d      = instr_i[3:0];
        pc_d       = pc_q + PC_W'(1);
        state_d    = S_EXEC;
        enter_exec = 1'b1;
      end
      S_EXEC: begin
        // Flags only move on real ALU ops; branches see the pre-EXEC flags
        if (exec_op >= 4'h2 && exec_op <= 4'h6) begin
          flag_z_d = alu_zero;
          flag_c_d = alu_carry;
        end
        if ((exec_op == OP_JMP) ||
            (exec_op == OP_JZ && flag_z_q) ||
            (exec_op == OP_JC && flag_c_q)) begin
          pc_d = PC_W'(imm_q);
        end
`ifdef SINGLE_STEP_EN
        state_d = S_PAUSE;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // EXEC outputs are registered, so decode one cycle ahead of EXEC
    if (enter_exec) begin
      if (dec_op == OP_MOV) begin
        rf_we_d  = 1'b1;
        wb_sel_d = 2'd2;
        alu_op_d = 3'd0;
      end else if (dec_op >= 4'h2 && dec_op <= 4'h6) begin
        rf_we_d  = 1'b1;
        wb_sel_d = 2'd0;
        alu_op_d = 3'(dec_op - 4'h2);
      end else if (dec_op == OP_LDI) begin
        rf_we_d  = 1'b1;
        wb_sel_d = 2'd1;
      end
    end

    busy_d   = (state_d == S_FETCH) || (state_d == S_FETCH2) || (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      imm_q    <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      rf_we_q  <= 1'b0;
      alu_op_q <= '0;
      wb_sel_q <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      rf_we_q  <= rf_we_d;
      alu_op_q <= alu_op_d;
      wb_sel_q <= wb_sel_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign pc_o        = pc_q;
  assign rf_r_addr_a = ir_q[1:0];
  assign rf_r_addr_b = ir_q[3:2];
  assign rf_w_addr   = ir_q[3:2];
  assign rf_we       = rf_we_q;
  assign alu_op      = alu_op_q;
  assign wb_sel      = wb_sel_q;
  assign imm_o       = imm_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;

endmodule
